// File: rtl/ins_issue_if.sv
// Bundle of host, program-memory and decoder-feedback signals around the issue controller.
// The master modport is the controller's view; slave is the surrounding system.
interface ins_issue_if #(
    parameter int INS_W     = 32,
    parameter int IMEMADDRW = 10,
    parameter int DLY_W     = 4
);
    logic                 start;
    logic [IMEMADDRW-1:0] start_addr;
    logic                 stall;
    logic                 imem_en;
    logic [IMEMADDRW-1:0] imem_addr;
    logic [INS_W-1:0]     imem_dout;
    logic [INS_W-1:0]     instruction;
    logic                 dec_delay_src_dst_sel;
    logic [DLY_W-1:0]     dec_delay_src_dst;
    logic                 dec_dst_jmp_addr_sel;
    logic [IMEMADDRW-1:0] dec_dst_jmp_addr;
    logic                 busy;
    logic                 done;
    logic [IMEMADDRW-1:0] pc;

    modport master (
        input  start, start_addr, stall, imem_dout,
               dec_delay_src_dst_sel, dec_delay_src_dst,
               dec_dst_jmp_addr_sel, dec_dst_jmp_addr,
        output imem_en, imem_addr, instruction, busy, done, pc
    );

    modport slave (
        output start, start_addr, stall, imem_dout,
               dec_delay_src_dst_sel, dec_delay_src_dst,
               dec_dst_jmp_addr_sel, dec_dst_jmp_addr,
        input  imem_en, imem_addr, instruction, busy, done, pc
    );
endinterface

// File: rtl/ins_issue_ctrl.sv
// Issue controller: fetches from synchronous program memory and feeds the decoder one
// instruction or nop per cycle, honouring decoder jumps/delays, external stall and halt.
module ins_issue_ctrl #(
    parameter int INS_W     = 32,
    parameter int IMEMADDRW = 10,
    parameter int DLY_W     = 4
) (
    input logic        clk,
    input logic        rst,
    ins_issue_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

    state_t               r_state;
    logic [INS_W-1:0]     r_ins_q;
    logic                 r_issue_v;
    logic [IMEMADDRW-1:0] r_pc;
    logic [DLY_W-1:0]     r_cnt;
    logic                 r_done;

    logic w_jump, w_delay, w_adv, w_halt, w_fetch_seq;

    // Decoder feedback is only trusted when a real instruction is on the bus.
    assign w_jump  = (r_state == RUN) && r_issue_v && bus.dec_dst_jmp_addr_sel;
    assign w_delay = (r_state == RUN) && r_issue_v && bus.dec_delay_src_dst_sel
                     && (bus.dec_delay_src_dst != '0);

    assign w_adv = ((r_state == RUN)  && !w_jump && !w_delay && !bus.stall) ||
                   ((r_state == WAIT) && (r_cnt == '0) && !bus.stall);
    assign w_halt      = w_adv && (&bus.imem_dout);
    assign w_fetch_seq = w_adv && !w_halt;

    always_comb begin
        bus.imem_en   = 1'b0;
        bus.imem_addr = r_pc;
        if (r_state == IDLE) begin
            bus.imem_en   = bus.start;
            bus.imem_addr = bus.start_addr;
        end else if (w_jump) begin
            bus.imem_en   = 1'b1;
            bus.imem_addr = bus.dec_dst_jmp_addr;
        end else if (w_fetch_seq) begin
            bus.imem_en   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ins_q   <= '0;
            r_issue_v <= 1'b0;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                r_ins_q   <= '0;
                r_issue_v <= 1'b0;
                if (bus.start) begin
                    r_pc    <= bus.start_addr + IMEMADDRW'(1);
                    r_state <= RUN;
                end
            end else begin
                if (w_jump)
                    r_pc <= bus.dec_dst_jmp_addr + IMEMADDRW'(1);
                else if (w_fetch_seq)
                    r_pc <= r_pc + IMEMADDRW'(1);

                if (w_halt) begin
                    r_ins_q   <= '0;
                    r_issue_v <= 1'b0;
                    r_state   <= IDLE;
                    r_done    <= 1'b1;
                end else if (w_adv) begin
                    r_ins_q   <= bus.imem_dout;
                    r_issue_v <= 1'b1;
                    r_state   <= RUN;
                end else begin
                    r_ins_q   <= '0;
                    r_issue_v <= 1'b0;
                    if (w_delay) begin
                        r_cnt   <= bus.dec_delay_src_dst - DLY_W'(1);
                        r_state <= WAIT;
                    end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - DLY_W'(1);
                    end
                end
            end
        end
    end

    assign bus.instruction = r_ins_q;
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.pc          = r_pc;
endmodule

// File: tb/tb_ins_issue_ctrl.sv
// Bench for ins_issue_ctrl: directed timing scenarios plus random programs checked
// against a program-walk model of the issued instruction stream.
module tb_ins_issue_ctrl;
    localparam int INS_W = 32, AW = 10, DW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ins_issue_if #(.INS_W(INS_W), .IMEMADDRW(AW), .DLY_W(DW)) bus();
    ins_issue_ctrl #(.INS_W(INS_W), .IMEMADDRW(AW), .DLY_W(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [INS_W-1:0] mem [0:(1<<AW)-1];
    logic [31:0]      junk = 32'h0;
    int n_tests = 0, n_fail = 0;

    // Fake decoder: bit31 jump (target in [9:0]), bit30 delay (D in [13:10]).
    // A nop produces garbage feedback, which the controller must ignore.
    wire nop = (bus.instruction == '0);
    assign bus.dec_dst_jmp_addr_sel  = nop ? junk[0]     : bus.instruction[31];
    assign bus.dec_dst_jmp_addr      = nop ? junk[10:1]  : bus.instruction[9:0];
    assign bus.dec_delay_src_dst_sel = nop ? junk[11]    : bus.instruction[30];
    assign bus.dec_delay_src_dst     = nop ? junk[15:12] : bus.instruction[13:10];

    always @(posedge clk) if (bus.imem_en) bus.imem_dout <= mem[bus.imem_addr];

    logic [31:0] tr_ins [0:31];
    logic        tr_done [0:31];
    logic        tr_busy [0:31];
    logic [AW-1:0] tr_pc [0:31];

    task automatic step();
        @(posedge clk); #1;
        junk = $urandom;
    endtask

    function automatic logic [31:0] mk_plain();
        logic [31:0] w = $urandom;
        w[31:28] = 4'b0001;
        return w;
    endfunction

    function automatic logic [31:0] mk_jump(input logic [AW-1:0] t);
        logic [31:0] w = $urandom;
        w[31:28] = 4'b1001;
        w[9:0] = t;
        return w;
    endfunction

    function automatic logic [31:0] mk_delay(input logic [DW-1:0] d);
        logic [31:0] w = $urandom;
        w[31:28] = 4'b0101;
        w[13:10] = d;
        return w;
    endfunction

    task automatic fill_junk();
        for (int i = 0; i < (1<<AW); i++) mem[i] = mk_plain();
    endtask

    // Cycle 0 is the cycle start is asserted; records outputs for cycles 0..n.
    task automatic run_trace(input logic [AW-1:0] sa, input int n, input int st_from, input int st_len);
        bus.start_addr = sa;
        bus.start = 1'b1;
        bus.stall = 1'b0;
        #1;
        tr_ins[0] = bus.instruction; tr_done[0] = bus.done; tr_busy[0] = bus.busy; tr_pc[0] = bus.pc;
        for (int c = 1; c <= n; c++) begin
            step();
            bus.start = 1'b0;
            bus.stall = (c >= st_from) && (c < st_from + st_len);
            tr_ins[c] = bus.instruction; tr_done[c] = bus.done; tr_busy[c] = bus.busy; tr_pc[c] = bus.pc;
        end
        bus.stall = 1'b0;
        step(); step();
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.start_addr = '0; bus.stall = 1'b0;
        rst = 1'b1;
        step(); step();
        n_tests++;
        if (bus.instruction !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.pc !== '0 || bus.imem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ins=%h busy=%b done=%b pc=%h en=%b, required all 0",
                     bus.instruction, bus.busy, bus.done, bus.pc, bus.imem_en);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic check_seq(input string nm, input logic [31:0] e[$], input int done_c);
        for (int c = 0; c < e.size(); c++) begin
            n_tests++;
            if (tr_ins[c] !== e[c]) begin
                n_fail++;
                $display("FAIL %s ins@c%0d: got %h, required %h", nm, c, tr_ins[c], e[c]);
            end
        end
        n_tests++;
        if (tr_done[done_c] !== 1'b1 || tr_busy[done_c] !== 1'b0 ||
            tr_done[done_c+1] !== 1'b0 || tr_done[done_c-1] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done@c%0d: done=%b%b%b busy=%b, required 010 busy 0", nm, done_c,
                     tr_done[done_c-1], tr_done[done_c], tr_done[done_c+1], tr_busy[done_c]);
        end
    endtask

    task automatic test_linear();
        logic [31:0] a = mk_plain(), b = mk_plain(), c = mk_plain();
        fill_junk();
        mem[10'h010] = a; mem[10'h011] = b; mem[10'h012] = c; mem[10'h013] = '1;
        run_trace(10'h010, 8, 99, 0);
        check_seq("linear", '{0, 0, a, b, c, 0, 0}, 5);
        n_tests++;
        if (tr_busy[0] !== 1'b0 || tr_busy[1] !== 1'b1 || tr_busy[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL linear busy: c0=%b c1=%b c4=%b, required 0 1 1", tr_busy[0], tr_busy[1], tr_busy[4]);
        end
    endtask

    task automatic test_jump(input int st_len);
        logic [31:0] a = mk_plain(), b = mk_jump(10'h020), c = mk_plain(), d = mk_plain();
        fill_junk();
        mem[10'h010] = a; mem[10'h011] = b; mem[10'h012] = c; mem[10'h020] = d; mem[10'h021] = '1;
        run_trace(10'h010, 9, 3, st_len);
        if (st_len == 0) begin
            check_seq("jump", '{0, 0, a, b, 0, d, 0}, 6);
            n_tests++;
            if (tr_pc[5] !== 10'h022) begin
                n_fail++;
                $display("FAIL jump pc: got %h, required 022", tr_pc[5]);
            end
        end else begin
            check_seq("jump_stall", '{0, 0, a, b, 0, 0, d, 0}, 7);
        end
    endtask

    task automatic test_delay(input logic [DW-1:0] d);
        logic [31:0] a = mk_delay(d), b = mk_plain();
        fill_junk();
        mem[10'h010] = a; mem[10'h011] = b; mem[10'h012] = '1;
        run_trace(10'h010, 9, 99, 0);
        if (d == 0) check_seq("delay0", '{0, 0, a, b, 0}, 4);
        else        check_seq("delay3", '{0, 0, a, 0, 0, 0, b, 0}, 7);
    endtask

    task automatic test_stall();
        logic [31:0] a = mk_plain(), b = mk_plain(), c = mk_plain();
        fill_junk();
        mem[10'h010] = a; mem[10'h011] = b; mem[10'h012] = c; mem[10'h013] = '1;
        run_trace(10'h010, 9, 3, 2);
        check_seq("stall", '{0, 0, a, b, 0, 0, c, 0}, 7);
    endtask

    task automatic test_wrap();
        logic [31:0] a = mk_plain(), b = mk_plain();
        fill_junk();
        mem[10'h3FF] = a; mem[10'h000] = b; mem[10'h001] = '1;
        bus.start_addr = 10'h3FF; bus.start = 1'b1; #1;
        n_tests++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h3FF) begin
            n_fail++;
            $display("FAIL wrap fetch: en=%b addr=%h, required 1 3ff", bus.imem_en, bus.imem_addr);
        end
        run_trace(10'h3FF, 7, 99, 0);
        check_seq("wrap", '{0, 0, a, b, 0}, 4);
        n_tests++;
        if (tr_pc[1] !== 10'h000) begin
            n_fail++;
            $display("FAIL wrap pc: got %h, required 000", tr_pc[1]);
        end
    endtask

    task automatic test_reset_mid_wait();
        fill_junk();
        mem[10'h010] = mk_delay(4'd8); mem[10'h011] = mk_plain(); mem[10'h012] = '1;
        bus.start_addr = 10'h010; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        step(); step(); step();
        n_tests++;
        if (bus.busy !== 1'b1 || bus.instruction !== '0) begin
            n_fail++;
            $display("FAIL mid_wait pre: busy=%b ins=%h, required 1 0", bus.busy, bus.instruction);
        end
        rst = 1'b1; #1;
        n_tests++;
        if (bus.instruction !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.pc !== '0 || bus.imem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait rst: ins=%h busy=%b done=%b pc=%h en=%b, required all 0",
                     bus.instruction, bus.busy, bus.done, bus.pc, bus.imem_en);
        end
        step(); rst = 1'b0; step();
        test_linear();
    endtask

    // Model: walk the program from start_addr, following jumps, until the halt word.
    task automatic test_random(input int iter);
        logic used [0:(1<<AW)-1];
        logic [31:0] expq[$], obsq[$], w;
        logic [AW-1:0] a, s, t, nx;
        int n_done, cyc;
        bit jmp;
        for (int i = 0; i < (1<<AW); i++) used[i] = 1'b0;
        fill_junk();
        s = AW'($urandom); a = s; used[a] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            nx = a + 1'b1;
            jmp = used[nx] || ($urandom_range(3) == 0);
            w = $urandom; w[31] = jmp; w[30] = ($urandom_range(2) == 0); w[29:28] = 2'b01;
            t = nx;
            if (jmp) begin
                do t = AW'($urandom); while (used[t]);
                w[9:0] = t;
            end
            mem[a] = w; expq.push_back(w);
            a = t; used[a] = 1'b1;
        end
        mem[a] = '1;
        bus.start_addr = s; bus.start = 1'b1; bus.stall = 1'b0;
        step(); bus.start = 1'b0;
        n_done = 0; cyc = 0;
        while (n_done == 0 && cyc < 3000) begin
            bus.stall = ($urandom_range(2) == 0);
            step(); cyc++;
            if (bus.instruction !== '0) obsq.push_back(bus.instruction);
            if (bus.done === 1'b1) n_done++;
        end
        bus.stall = 1'b0;
        n_tests++;
        if (n_done == 0 || obsq.size() != expq.size()) begin
            n_fail++;
            $display("FAIL random%0d length: issued %0d done=%0d, required %0d done=1",
                     iter, obsq.size(), n_done, expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            n_tests++;
            if (obsq[i] !== expq[i]) begin
                n_fail++;
                $display("FAIL random%0d ins[%0d]: got %h, required %h", iter, i, obsq[i], expq[i]);
            end
        end
        step();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL random%0d idle: busy=%b done=%b, required 0 0", iter, bus.busy, bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_jump(0);
        test_jump(2);
        test_delay(4'd3);
        test_delay(4'd0);
        test_stall();
        test_wrap();
        test_reset_mid_wait();
        for (int i = 0; i < 8; i++) test_random(i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
